prbs_check_v: RTL and testbench
===============================

PRBS_CHECK_V -- requirements
Module: prbsCheckV

Interface
REQ-001 Parameter LOCK_CNT, default 64, consecutive correct predictions required to declare lock.
REQ-002 Parameter WIN, default 256, length in bits of the error-monitoring window while locked.
REQ-003 Parameter ERR_THR, default 8, errors within one window that force loss of lock.
REQ-004 Parameter CNT_W, default 16, width of the error counter.
REQ-005 Port clkV  input  1  sole clock; all state changes on the rising edge.
REQ-006 Port rstV  input  1  reset; synchronous, active-high.
REQ-007 Port inV  input  1  received serial bit; one bit is sampled per rising edge of clkV.
REQ-008 Port clrV  input  1  synchronous clear of errCntV and bitCntV.
REQ-009 Port lockV  output  1  high while the checker is in LOCKED.
REQ-010 Port errV  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-011 Port errCntV  output  CNT_W  saturating count of mismatches while LOCKED.
REQ-012 Port bitCntV  output  32  saturating count of bits compared while LOCKED.

Function
REQ-013 The block SHALL check a PRBS sequence obeying b[n+1] = NOT(b[n-31] XOR b[n-21] XOR b[n-1] XOR b[n]), i.e. 32-bit XNOR LFSR, taps 31/21/1/0, newest bit at index 0.
REQ-014 It SHALL keep a 32-bit history h (h[0] newest); prediction pred = NOT(h[31] XOR h[21] XOR h[1] XOR h[0]).
REQ-015 States SHALL be SEARCH and LOCKED; reset state SEARCH.
REQ-016 SEARCH: each edge h <= {h[30:0], inV}; fill counter increments, saturates at 32.
REQ-017 SEARCH with fill = 32: inV == pred increments run counter; mismatch clears run to 0.
REQ-018 SEARCH: if the 32-bit history is all ones, no match is counted (run held at 0), preventing lock on the XNOR lockup pattern or a stuck-high line.
REQ-019 SEARCH: when run reaches LOCK_CNT, state SHALL become LOCKED on that same edge; window bit and window error counters cleared.
REQ-020 LOCKED: history free-runs on its own prediction, h <= {h[30:0], pred}; inV is compared only, never shifted in, so a single line error yields exactly one errV pulse.
REQ-021 LOCKED: inV != pred SHALL set errV = 1 for exactly the next cycle, increment errCntV (saturate at 2^CNT_W-1) and the window error counter.
REQ-022 LOCKED: every sampled bit increments bitCntV (saturate at 2^32-1) and the window bit counter (0..WIN-1, wraps to 0).
REQ-023 If the window error counter reaches ERR_THR, state SHALL return to SEARCH on that edge with fill = 0, run = 0; errCntV/bitCntV retained.
REQ-024 An error on the last bit of a window counts toward the closing window, evaluated against ERR_THR before the window error counter clears on wrap.
REQ-025 clrV = 1 SHALL zero errCntV and bitCntV on that edge, with priority over a simultaneous increment; state, history and window counters unaffected.
REQ-026 All outputs SHALL be registered; lockV reflects the state register; latency inV sample -> errV is one edge.
REQ-027 errCntV and bitCntV SHALL not change in SEARCH (except by clrV).

Reset
REQ-028 rstV = 1 at a rising edge SHALL set state SEARCH, h = 0, fill = 0, run = 0, window counters = 0, lockV = 0, errV = 0, errCntV = 0, bitCntV = 0.
REQ-029 Reset SHALL take priority over clrV and all other activity, including mid-lock.
REQ-030 The first bit sampled after rstV deasserts SHALL be treated as history bit 1 of 32.

Verification
REQ-031 Drive inV from a 32-bit XNOR LFSR seeded 0xFFFFFFFE (taps 31/21/1/0, output bit 0) -> lockV = 1 after the 96th sampling edge (32 fill + 64 matches), errV never asserts, bitCntV increments by 1 per edge thereafter.
REQ-032 Locked, invert one bit -> one errV pulse, errCntV = 1, lockV stays 1, no further errors.
REQ-033 Locked, invert 8 bits within one 256-bit window -> lockV = 0 on the edge sampling the 8th error; errCntV = 8; relock 96 edges later on clean data.
REQ-034 inV held at 1 or at 0 for 1000 edges -> lockV never asserts.
REQ-035 Locked with errCntV = 5, assert clrV together with a mismatched bit -> errCntV = 0, bitCntV = 0, errV pulses once, lockV stays 1.
REQ-036 rstV pulsed for one edge while locked -> lockV, errV, errCntV, bitCntV all 0 on the next cycle; relock after 96 further edges.

Source files
------------

// File: rtl/prbs_check_v.sv
// rtl/prbs_check_v.sv - 32-bit XNOR LFSR (taps 31/21/1/0) sequence checker with lock search and windowed loss of lock
module prbs_check_v #(
    parameter int LOCK_CNT = 64,
    parameter int WIN      = 256,
    parameter int ERR_THR  = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clkV,
    input  logic             rstV,
    input  logic             inV,
    input  logic             clrV,
    output logic             lockV,
    output logic             errV,
    output logic [CNT_W-1:0] errCntV,
    output logic [31:0]      bitCntV
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WBIT_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int WERR_W = $clog2(ERR_THR + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } stateT;

    stateT             stateQ;
    stateT             stateD;
    logic [31:0]       histQ;
    logic [5:0]        fillQ;
    logic [RUN_W-1:0]  runQ;
    logic [WBIT_W-1:0] winBitQ;
    logic [WERR_W-1:0] winErrQ;

    logic              pred;
    logic              mismatch;
    logic              fillFull;
    logic              histAllOnes;
    logic              matchOk;
    logic [RUN_W-1:0]  runNext;
    logic              lockHit;
    logic [WERR_W-1:0] winErrSum;
    logic              winWrap;
    logic              lossHit;

    // An all-ones history is the XNOR lockup state; it predicts itself forever,
    // so it must never count toward lock.
    always_comb begin
        pred        = ~(histQ[31] ^ histQ[21] ^ histQ[1] ^ histQ[0]);
        mismatch    = inV ^ pred;
        fillFull    = (fillQ == 6'd32);
        histAllOnes = &histQ;
        matchOk     = fillFull && !mismatch && !histAllOnes;
        runNext     = runQ + RUN_W'(1);
        lockHit     = matchOk && (runNext == RUN_W'(LOCK_CNT));
        winErrSum   = winErrQ + WERR_W'(mismatch);
        winWrap     = (winBitQ == WBIT_W'(WIN - 1));
        lossHit     = mismatch && (winErrSum >= WERR_W'(ERR_THR));
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            SEARCH: if (lockHit) stateD = LOCKED;
            LOCKED: if (lossHit) stateD = SEARCH;
            default: stateD = SEARCH;
        endcase
    end

    assign lockV = (stateQ == LOCKED);

    always_ff @(posedge clkV) begin
        if (rstV) begin
            stateQ  <= SEARCH;
            histQ   <= '0;
            fillQ   <= '0;
            runQ    <= '0;
            winBitQ <= '0;
            winErrQ <= '0;
            errV    <= 1'b0;
            errCntV <= '0;
            bitCntV <= '0;
        end else begin
            stateQ <= stateD;
            errV   <= (stateQ == LOCKED) && mismatch;

            if (stateQ == SEARCH) begin
                histQ <= {histQ[30:0], inV};
                if (!fillFull) begin
                    fillQ <= fillQ + 6'd1;
                end else begin
                    runQ <= matchOk ? runNext : '0;
                end
                if (lockHit) begin
                    runQ    <= '0;
                    winBitQ <= '0;
                    winErrQ <= '0;
                end
            end else begin
                // Free-running on prediction keeps a line error from corrupting the history.
                histQ <= {histQ[30:0], pred};
                if (lossHit) begin
                    fillQ   <= '0;
                    runQ    <= '0;
                    winBitQ <= '0;
                    winErrQ <= '0;
                end else begin
                    winBitQ <= winWrap ? '0 : winBitQ + WBIT_W'(1);
                    winErrQ <= winWrap ? '0 : winErrSum;
                end
            end

            if (clrV) begin
                errCntV <= '0;
                bitCntV <= '0;
            end else if (stateQ == LOCKED) begin
                if (bitCntV != 32'hFFFF_FFFF) begin
                    bitCntV <= bitCntV + 32'd1;
                end
                if (mismatch && (errCntV != {CNT_W{1'b1}})) begin
                    errCntV <= errCntV + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_prbs_check_v.sv
// tb/tb_prbs_check_v.sv - directed self-checking bench for prbs_check_v
module tb_prbs_check_v;
    logic        clkV = 1'b0;
    logic        rstV = 1'b1;
    logic        inV  = 1'b0;
    logic        clrV = 1'b0;
    logic        lockV;
    logic        errV;
    logic [15:0] errCntV;
    logic [31:0] bitCntV;

    int          nAssert = 0;
    int          nFail   = 0;
    logic [31:0] genS;

    prbs_check_v #(
        .LOCK_CNT(64),
        .WIN     (256),
        .ERR_THR (8),
        .CNT_W   (16)
    ) dut (
        .clkV   (clkV),
        .rstV   (rstV),
        .inV    (inV),
        .clrV   (clrV),
        .lockV  (lockV),
        .errV   (errV),
        .errCntV(errCntV),
        .bitCntV(bitCntV)
    );

    always #5 clkV = ~clkV;

    // Next generator bit (optionally inverted on the line), then one edge.
    task automatic sendBit(input bit flip, input bit clr);
        inV  = genS[0] ^ flip;
        clrV = clr;
        genS = {genS[30:0], ~(genS[31] ^ genS[21] ^ genS[1] ^ genS[0])};
        @(posedge clkV);
        #1;
    endtask

    task automatic driveRaw(input bit b);
        inV  = b;
        clrV = 1'b0;
        @(posedge clkV);
        #1;
    endtask

    task automatic test_reset;
        rstV = 1'b1;
        clrV = 1'b1;
        inV  = 1'b1;
        @(posedge clkV);
        #1;
        nAssert++; if (lockV !== 1'b0) begin nFail++; $display("FAIL reset_lock got %b want 0", lockV); end
        nAssert++; if (errV !== 1'b0) begin nFail++; $display("FAIL reset_err got %b want 0", errV); end
        nAssert++; if (errCntV !== 16'd0) begin nFail++; $display("FAIL reset_errcnt got %0d want 0", errCntV); end
        nAssert++; if (bitCntV !== 32'd0) begin nFail++; $display("FAIL reset_bitcnt got %0d want 0", bitCntV); end
        clrV = 1'b0;
    endtask

    task automatic test_lock;
        bit early = 1'b0;
        bit anyErr = 1'b0;
        rstV = 1'b0;
        genS = 32'hFFFF_FFFE;
        for (int k = 1; k <= 96; k++) begin
            sendBit(1'b0, 1'b0);
            if (k < 96 && lockV) early = 1'b1;
            if (errV) anyErr = 1'b1;
        end
        nAssert++; if (early !== 1'b0) begin nFail++; $display("FAIL lock_early got %b want 0", early); end
        nAssert++; if (lockV !== 1'b1) begin nFail++; $display("FAIL lock_at_96 got %b want 1", lockV); end
        nAssert++; if (anyErr !== 1'b0) begin nFail++; $display("FAIL lock_err_seen got %b want 0", anyErr); end
        nAssert++; if (bitCntV !== 32'd0) begin nFail++; $display("FAIL lock_bitcnt got %0d want 0", bitCntV); end
        for (int k = 1; k <= 10; k++) begin
            sendBit(1'b0, 1'b0);
            nAssert++; if (bitCntV !== 32'(k)) begin nFail++; $display("FAIL clean_bitcnt got %0d want %0d", bitCntV, k); end
            nAssert++; if (errV !== 1'b0) begin nFail++; $display("FAIL clean_err got %b want 0", errV); end
        end
    endtask

    task automatic test_single_error;
        bit anyErr = 1'b0;
        sendBit(1'b1, 1'b0);
        nAssert++; if (errV !== 1'b1) begin nFail++; $display("FAIL single_errv got %b want 1", errV); end
        nAssert++; if (errCntV !== 16'd1) begin nFail++; $display("FAIL single_errcnt got %0d want 1", errCntV); end
        nAssert++; if (lockV !== 1'b1) begin nFail++; $display("FAIL single_lock got %b want 1", lockV); end
        for (int k = 0; k < 21; k++) begin
            sendBit(1'b0, 1'b0);
            if (errV) anyErr = 1'b1;
        end
        nAssert++; if (anyErr !== 1'b0) begin nFail++; $display("FAIL single_extra_err got %b want 0", anyErr); end
        nAssert++; if (errCntV !== 16'd1) begin nFail++; $display("FAIL single_errcnt_after got %0d want 1", errCntV); end
        nAssert++; if (bitCntV !== 32'd32) begin nFail++; $display("FAIL single_bitcnt got %0d want 32", bitCntV); end
    endtask

    // 7 errors closing one window, 1 opening the next: the wrap must clear the count.
    task automatic test_window_wrap;
        repeat (217) sendBit(1'b0, 1'b0);
        repeat (6) sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        nAssert++; if (lockV !== 1'b1) begin nFail++; $display("FAIL wrap_lock got %b want 1", lockV); end
        nAssert++; if (errCntV !== 16'd8) begin nFail++; $display("FAIL wrap_errcnt got %0d want 8", errCntV); end
        nAssert++; if (bitCntV !== 32'd257) begin nFail++; $display("FAIL wrap_bitcnt got %0d want 257", bitCntV); end
    endtask

    // 8th error of the window lands on its last bit.
    task automatic test_last_bit_loss;
        bit early = 1'b0;
        bit anyErr = 1'b0;
        repeat (248) sendBit(1'b0, 1'b0);
        repeat (6) sendBit(1'b1, 1'b0);
        nAssert++; if (lockV !== 1'b1) begin nFail++; $display("FAIL loss_pre_lock got %b want 1", lockV); end
        sendBit(1'b1, 1'b0);
        nAssert++; if (lockV !== 1'b0) begin nFail++; $display("FAIL loss_lock got %b want 0", lockV); end
        nAssert++; if (errV !== 1'b1) begin nFail++; $display("FAIL loss_errv got %b want 1", errV); end
        nAssert++; if (errCntV !== 16'd15) begin nFail++; $display("FAIL loss_errcnt got %0d want 15", errCntV); end
        nAssert++; if (bitCntV !== 32'd512) begin nFail++; $display("FAIL loss_bitcnt got %0d want 512", bitCntV); end
        for (int k = 1; k <= 96; k++) begin
            sendBit(1'b0, 1'b0);
            if (k < 96 && lockV) early = 1'b1;
            if (errV) anyErr = 1'b1;
        end
        nAssert++; if (early !== 1'b0) begin nFail++; $display("FAIL relock_early got %b want 0", early); end
        nAssert++; if (lockV !== 1'b1) begin nFail++; $display("FAIL relock_at_96 got %b want 1", lockV); end
        nAssert++; if (anyErr !== 1'b0) begin nFail++; $display("FAIL relock_err_seen got %b want 0", anyErr); end
        nAssert++; if (errCntV !== 16'd15) begin nFail++; $display("FAIL search_errcnt got %0d want 15", errCntV); end
        nAssert++; if (bitCntV !== 32'd512) begin nFail++; $display("FAIL search_bitcnt got %0d want 512", bitCntV); end
    endtask

    task automatic test_clear_collision;
        sendBit(1'b0, 1'b1);
        nAssert++; if (errCntV !== 16'd0) begin nFail++; $display("FAIL clr_errcnt got %0d want 0", errCntV); end
        nAssert++; if (bitCntV !== 32'd0) begin nFail++; $display("FAIL clr_bitcnt got %0d want 0", bitCntV); end
        repeat (5) begin
            sendBit(1'b1, 1'b0);
            sendBit(1'b0, 1'b0);
        end
        nAssert++; if (errCntV !== 16'd5) begin nFail++; $display("FAIL pre_coll_errcnt got %0d want 5", errCntV); end
        nAssert++; if (bitCntV !== 32'd10) begin nFail++; $display("FAIL pre_coll_bitcnt got %0d want 10", bitCntV); end
        sendBit(1'b1, 1'b1);
        nAssert++; if (errCntV !== 16'd0) begin nFail++; $display("FAIL coll_errcnt got %0d want 0", errCntV); end
        nAssert++; if (bitCntV !== 32'd0) begin nFail++; $display("FAIL coll_bitcnt got %0d want 0", bitCntV); end
        nAssert++; if (errV !== 1'b1) begin nFail++; $display("FAIL coll_errv got %b want 1", errV); end
        nAssert++; if (lockV !== 1'b1) begin nFail++; $display("FAIL coll_lock got %b want 1", lockV); end
        sendBit(1'b0, 1'b0);
        nAssert++; if (errV !== 1'b0) begin nFail++; $display("FAIL coll_errv_after got %b want 0", errV); end
        nAssert++; if (bitCntV !== 32'd1) begin nFail++; $display("FAIL coll_bitcnt_after got %0d want 1", bitCntV); end
    endtask

    task automatic test_reset_mid_lock;
        bit early = 1'b0;
        sendBit(1'b1, 1'b0);
        nAssert++; if (errV !== 1'b1) begin nFail++; $display("FAIL prerst_errv got %b want 1", errV); end
        rstV = 1'b1;
        sendBit(1'b1, 1'b1);
        rstV = 1'b0;
        nAssert++; if (lockV !== 1'b0) begin nFail++; $display("FAIL midrst_lock got %b want 0", lockV); end
        nAssert++; if (errV !== 1'b0) begin nFail++; $display("FAIL midrst_errv got %b want 0", errV); end
        nAssert++; if (errCntV !== 16'd0) begin nFail++; $display("FAIL midrst_errcnt got %0d want 0", errCntV); end
        nAssert++; if (bitCntV !== 32'd0) begin nFail++; $display("FAIL midrst_bitcnt got %0d want 0", bitCntV); end
        for (int k = 1; k <= 96; k++) begin
            sendBit(1'b0, 1'b0);
            if (k < 96 && lockV) early = 1'b1;
        end
        nAssert++; if (early !== 1'b0) begin nFail++; $display("FAIL rstlock_early got %b want 0", early); end
        nAssert++; if (lockV !== 1'b1) begin nFail++; $display("FAIL rstlock_at_96 got %b want 1", lockV); end
    endtask

    task automatic test_stuck_line;
        bit sawLock;
        for (int v = 0; v < 2; v++) begin
            sawLock = 1'b0;
            rstV = 1'b1;
            driveRaw(1'b0);
            rstV = 1'b0;
            repeat (1000) begin
                driveRaw(v[0] ? 1'b0 : 1'b1);
                if (lockV) sawLock = 1'b1;
            end
            nAssert++; if (sawLock !== 1'b0) begin nFail++; $display("FAIL stuck%0d_lock got %b want 0", v, sawLock); end
            nAssert++; if (bitCntV !== 32'd0) begin nFail++; $display("FAIL stuck%0d_bitcnt got %0d want 0", v, bitCntV); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_window_wrap();
        test_last_bit_loss();
        test_clear_collision();
        test_reset_mid_lock();
        test_stuck_line();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
